// File: rtl/cls_8bit_adder.sv
// 8-bit carry-select adder: low nibble ripples from carry_start, the high nibble is
// precomputed for both carry-ins and selected by c4; result captured in output registers.

module cls_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic xy_x;

    assign xy_x = x ^ y;
    assign s    = xy_x ^ ci;
    assign co   = (x & y) | (ci & xy_x);
endmodule

module cls_ripple4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cell
            cls_full_adder u_fa (
                .x  (x[gi]),
                .y  (y[gi]),
                .ci (c[gi]),
                .s  (s[gi]),
                .co (c[gi+1])
            );
        end
    endgenerate

    assign co = c[4];
endmodule

module cls_8bit_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_start,
    output logic [7:0] sum,
    output logic       carry_out
);
    logic [3:0] lo_sum;
    logic       c4;
    logic [3:0] hi_sum_c0;
    logic [3:0] hi_sum_c1;
    logic       hi_co_c0;
    logic       hi_co_c1;

    logic [7:0] sum_next;
    logic       carry_next;
    logic [7:0] sum_reg;
    logic       carry_reg;

    cls_ripple4 u_lo (
        .x  (a[3:0]),
        .y  (b[3:0]),
        .ci (carry_start),
        .s  (lo_sum),
        .co (c4)
    );

    // Both high-nibble candidates settle in parallel with the low chain.
    cls_ripple4 u_hi_c0 (
        .x  (a[7:4]),
        .y  (b[7:4]),
        .ci (1'b0),
        .s  (hi_sum_c0),
        .co (hi_co_c0)
    );

    cls_ripple4 u_hi_c1 (
        .x  (a[7:4]),
        .y  (b[7:4]),
        .ci (1'b1),
        .s  (hi_sum_c1),
        .co (hi_co_c1)
    );

    always_comb begin
        sum_next   = {hi_sum_c0, lo_sum};
        carry_next = hi_co_c0;
        if (c4) begin
            sum_next   = {hi_sum_c1, lo_sum};
            carry_next = hi_co_c1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg   <= 8'h00;
            carry_reg <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
        end
    end

    assign sum       = sum_reg;
    assign carry_out = carry_reg;
endmodule

// File: tb/tb_cls_8bit_adder.sv
// Scoreboard bench for cls_8bit_adder: stimulus pushes expected 9-bit results,
// a monitor pops and compares one cycle later, after every rising edge.

module tb_cls_8bit_adder;
    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_start;
    logic [7:0] sum;
    logic       carry_out;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } txn_t;

    txn_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    cls_8bit_adder dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .carry_start (carry_start),
        .sum         (sum),
        .carry_out   (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 9-bit unsigned addition; reset forces zero.
    function automatic logic [8:0] model(input logic r, input logic [7:0] x,
                                         input logic [7:0] y, input logic c);
        logic [8:0] res;
        if (r) res = 9'h000;
        else   res = {1'b0, x} + {1'b0, y} + {8'h00, c};
        return res;
    endfunction

    // Drive one cycle's inputs (called at a falling edge) and push the expectation.
    task automatic apply(input logic r, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input string name);
        txn_t t;
        rst         = r;
        a           = x;
        b           = y;
        carry_start = c;
        t.exp       = model(r, x, y, c);
        t.name      = name;
        sb_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic check_now(input logic [8:0] exp, input string name);
        tests_run++;
        if ({carry_out, sum} !== exp) begin
            tests_failed++;
            $display("FAIL %s: got sum=%h carry_out=%b, expected sum=%h carry_out=%b",
                     name, sum, carry_out, exp[7:0], exp[8]);
        end
    endtask

    // Monitor: every rising edge presents one result.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL scoreboard_underflow: got no pending expectation, expected one");
            end else begin
                t = sb_q.pop_front();
                check_now(t.exp, t.name);
                $display("[TB] %s rst=%b a=%h b=%h cs=%b -> sum=%h co=%b", t.name, rst, a, b,
                         carry_start, sum, carry_out);
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; a = 8'h00; b = 8'h00; carry_start = 1'b0;

        // Reset held with nonzero inputs, then the first edge after release.
        apply(1'b1, 8'h3C, 8'h5A, 1'b1, "reset_hold");
        apply(1'b1, 8'h3C, 8'h5A, 1'b1, "reset_hold");
        apply(1'b0, 8'h3C, 8'h5A, 1'b1, "first_after_release");

        // Asynchronous reset: outputs clear before any rising edge.
        apply(1'b0, 8'h55, 8'h22, 1'b0, "pre_async");
        rst = 1'b1;
        a   = 8'hAA;
        #1;
        check_now(9'h000, "async_reset_immediate");
        apply(1'b1, 8'hAA, 8'h11, 1'b1, "async_reset_hold");
        apply(1'b0, 8'h12, 8'h34, 1'b0, "async_release");

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                apply(1'b0, 8'(i), 8'(j), 1'b1, "low_sweep");

        apply(1'b0, 8'h08, 8'h08, 1'b0, "nibble_carry");
        apply(1'b0, 8'h0F, 8'h00, 1'b1, "c4_select");
        apply(1'b0, 8'h80, 8'h80, 1'b0, "wrap_80_80");
        apply(1'b0, 8'hFF, 8'h00, 1'b1, "wrap_ff_00_1");
        apply(1'b0, 8'hFF, 8'hFF, 1'b1, "wrap_ff_ff_1");
        apply(1'b0, 8'h01, 8'h01, 1'b0, "pipe_first");
        apply(1'b0, 8'h10, 8'h20, 1'b1, "pipe_second");

        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    apply(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), "random_reset");
            end
            apply(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "random");
        end

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
